draw_sprite_engine: RTL

DRAW_SPRITE_ENGINE -- requirements
Module: draw_sprite_engine

---
 rtl/draw_sprite_engine_if.sv | 35 +++
 rtl/draw_sprite_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite_engine_if.sv
// ----------------------------------------------------------------------------
// draw_sprite_engine_if
// Groups the signals between the sprite draw engine and its surroundings.
//   Request side : enable, sprite_sel, base_x, base_y    (to engine)
//   Status       : done, busy                            (from engine)
//   Sprite ROM   : rom_addr (from engine), rom_data (to engine, 1-cycle latency)
//   VGA adapter  : vga_x, vga_y, vga_colour, vga_plot    (from engine)
// Modports:
//   slave  - the draw engine
//   master - the environment (view FSM, sprite ROM, VGA adapter, testbench)
// ----------------------------------------------------------------------------
interface draw_sprite_engine_if;
    logic       enable;
    logic [1:0] sprite_sel;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [9:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       done;
    logic       busy;

    modport slave (
        input  enable, sprite_sel, base_x, base_y, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, vga_plot, done, busy
    );

    modport master (
        output enable, sprite_sel, base_x, base_y, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, done, busy
    );
endinterface

// File: rtl/draw_sprite_engine.sv
// ----------------------------------------------------------------------------
// draw_sprite_engine
// Walks one SPR_W x SPR_H sprite out of a synchronous sprite ROM and writes
// its non-transparent, on-screen pixels to a VGA adapter, one per cycle.
//
// Ports:
//   clk     - single clock, rising edge
//   resetn  - asynchronous, active-low reset
//   bus     - draw_sprite_engine_if.slave (request, status, ROM, VGA signals)
//
// Sequence: IDLE -> SCAN (SPR_W*SPR_H cycles, one ROM address per cycle)
//           -> FLUSH (1 cycle, last pixel) -> DONE (until enable drops).
// Dropping enable in SCAN or FLUSH aborts the draw back to IDLE.
// ----------------------------------------------------------------------------
module draw_sprite_engine #(
    parameter int unsigned SPR_W       = 16,
    parameter int unsigned SPR_H       = 16,
    parameter logic [2:0]  TRANSPARENT = 3'b000,
    parameter int unsigned SCR_W       = 160,
    parameter int unsigned SCR_H       = 120
) (
    input logic                 clk,
    input logic                 resetn,
    draw_sprite_engine_if.slave bus
);

    localparam int unsigned CW   = $clog2(SPR_W);
    localparam int unsigned RW   = $clog2(SPR_H);
    localparam int unsigned AREA = SPR_W * SPR_H;

    localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);
    localparam logic [8:0]    X_LIM   = 9'(SCR_W);
    localparam logic [7:0]    Y_LIM   = 8'(SCR_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q;

    // Request latched at IDLE->SCAN; inputs are ignored for the rest of the draw.
    logic [1:0]    sel_q;
    logic [7:0]    bx_q;
    logic [6:0]    by_q;

    // Row/column of the address currently on rom_addr.
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [9:0]    rom_addr_q;

    // Pixel stage: screen position of the address issued last cycle, one bit
    // wider than the VGA coordinates so a carry marks the pixel off-screen.
    logic [8:0]    px_q;
    logic [7:0]    py_q;
    logic          pv_q;

    logic          done_q;
    logic          busy_q;

    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic [9:0]    rom_addr_d;
    logic [9:0]    start_addr_d;
    logic          last_addr;
    logic          on_screen;

    function automatic logic [9:0] addr_of(input logic [1:0]    s,
                                           input logic [RW-1:0] r,
                                           input logic [CW-1:0] c);
        return 10'(32'(s) * AREA + 32'(r) * SPR_W + 32'(c));
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        last_addr    = (col_q == COL_MAX) && (row_q == ROW_MAX);
        col_d        = col_q + CW'(1);
        row_d        = (col_q == COL_MAX) ? row_q + RW'(1) : row_q;
        rom_addr_d   = addr_of(sel_q, row_d, col_d);
        start_addr_d = addr_of(bus.sprite_sel, '0, '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    // NOTE: the pixel stage is reset along with the FSM because the VGA
    // outputs are driven straight from it and must read 0 during reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pv_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pv_q   <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.enable) begin
                        sel_q      <= bus.sprite_sel;
                        bx_q       <= bus.base_x;
                        by_q       <= bus.base_y;
                        col_q      <= '0;
                        row_q      <= '0;
                        rom_addr_q <= start_addr_d;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end

                SCAN: begin
                    if (!bus.enable) begin
                        pv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        // ROM data for this address arrives next cycle, so its
                        // screen position is carried alongside for one stage.
                        px_q       <= {1'b0, bx_q} + 9'(col_q);
                        py_q       <= {1'b0, by_q} + 8'(row_q);
                        pv_q       <= 1'b1;
                        col_q      <= col_d;
                        row_q      <= row_d;
                        rom_addr_q <= rom_addr_d;
                        if (last_addr) begin
                            state_q <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    pv_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (!bus.enable) begin
                        state_q <= IDLE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    pv_q   <= 1'b0;
                    busy_q <= 1'b0;
                    // A new request needs enable to drop first; holding it
                    // high simply keeps done asserted.
                    if (!bus.enable) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Clipping: a carry out of either sum is treated as off-screen.
    assign on_screen = !px_q[8] && (px_q < X_LIM) && !py_q[7] && (py_q < Y_LIM);

    assign bus.rom_addr   = rom_addr_q;
    assign bus.vga_x      = px_q[7:0];
    assign bus.vga_y      = py_q[6:0];
    assign bus.vga_colour = pv_q ? bus.rom_data : 3'b000;
    assign bus.vga_plot   = pv_q && (bus.rom_data != TRANSPARENT) && on_screen;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

endmodule
